// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the RV32I MEM stage: dataMem one-hot opcodes, exception causes
// and FSM states.
package mem_access_stage_pkg;

  localparam int OP_LB  = 10;
  localparam int OP_LH  = 11;
  localparam int OP_LW  = 12;
  localparam int OP_LBU = 13;
  localparam int OP_LHU = 14;
  localparam int OP_SB  = 15;
  localparam int OP_SH  = 16;
  localparam int OP_SW  = 17;

  localparam logic [63:0] INST_LB  = 64'd1 << OP_LB;
  localparam logic [63:0] INST_LH  = 64'd1 << OP_LH;
  localparam logic [63:0] INST_LW  = 64'd1 << OP_LW;
  localparam logic [63:0] INST_LBU = 64'd1 << OP_LBU;
  localparam logic [63:0] INST_LHU = 64'd1 << OP_LHU;
  localparam logic [63:0] INST_SB  = 64'd1 << OP_SB;
  localparam logic [63:0] INST_SH  = 64'd1 << OP_SH;
  localparam logic [63:0] INST_SW  = 64'd1 << OP_SW;

  localparam logic [63:0] LOAD_MASK  = INST_LB | INST_LH | INST_LW | INST_LBU | INST_LHU;
  localparam logic [63:0] STORE_MASK = INST_SB | INST_SH | INST_SW;
  localparam logic [63:0] HALF_MASK  = INST_LH | INST_LHU | INST_SH;
  localparam logic [63:0] WORD_MASK  = INST_LW | INST_SW;

  typedef enum logic [1:0] {
    EXC_NONE      = 2'b00,
    EXC_LOAD_MIS  = 2'b01,
    EXC_STORE_MIS = 2'b10,
    EXC_RANGE     = 2'b11
  } exc_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_HOLD    = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// EX request, dataMem request/response and WB record channels of the MEM stage.
interface mem_access_stage_if #(
  parameter int XLEN   = 32,
  parameter int INST_W = 64
);
  logic              ex_valid;
  logic              ex_ready;
  logic [INST_W-1:0] ex_inst;
  logic [XLEN-1:0]   ex_rs1;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_rs2;
  logic [4:0]        ex_rd;
  logic [XLEN-1:0]   ex_alu_result;

  logic [INST_W-1:0] dmem_inst;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN-1:0]   dmem_rdata;

  logic              wb_valid;
  logic              wb_ready;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              exc_valid;
  logic [1:0]        exc_cause;
  logic [XLEN-1:0]   exc_addr;

  modport master (
    input  ex_valid, ex_inst, ex_rs1, ex_imm, ex_rs2, ex_rd, ex_alu_result,
    output ex_ready,
    output dmem_inst, dmem_addr, dmem_wdata,
    input  dmem_rdata,
    output wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_cause, exc_addr,
    input  wb_ready
  );

  modport slave (
    output ex_valid, ex_inst, ex_rs1, ex_imm, ex_rs2, ex_rd, ex_alu_result,
    input  ex_ready,
    input  dmem_inst, dmem_addr, dmem_wdata,
    output dmem_rdata,
    input  wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_cause, exc_addr,
    output wb_ready
  );
endinterface

// File: rtl/mem_align_check.sv
// Classifies a one-hot op as load/store and flags misaligned or out-of-range addresses;
// misalignment takes priority over range.
module mem_align_check
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int INST_W   = 64,
  parameter int MEM_SIZE = 4096
) (
  input  logic [XLEN-1:0]   ea,
  input  logic [INST_W-1:0] op,
  output logic              is_load,
  output logic              is_store,
  output logic              fault,
  output exc_cause_t        cause
);
  logic is_half;
  logic is_word;
  logic misaligned;
  logic out_of_range;

  assign is_load      = |(op & INST_W'(LOAD_MASK));
  assign is_store     = |(op & INST_W'(STORE_MASK));
  assign is_half      = |(op & INST_W'(HALF_MASK));
  assign is_word      = |(op & INST_W'(WORD_MASK));
  assign misaligned   = (is_half & ea[0]) | (is_word & (ea[1:0] != 2'b00));
  assign out_of_range = (is_load | is_store) & (ea >= XLEN'(MEM_SIZE));
  assign fault        = misaligned | out_of_range;

  always_comb begin
    cause = EXC_NONE;
    if (misaligned)        cause = is_load ? EXC_LOAD_MIS : EXC_STORE_MIS;
    else if (out_of_range) cause = EXC_RANGE;
  end
endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: one transaction in flight, drives dataMem for exactly one cycle per
// legal access and presents a write-back record to WB over valid/ready.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int INST_W   = 64,
  parameter int MEM_SIZE = 4096
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_stage_if.master bus
);
  state_t            state;
  state_t            next_state;
  state_t            target;
  logic [XLEN-1:0]   ea;
  logic              is_load;
  logic              is_store;
  logic              is_mem;
  logic              fault;
  exc_cause_t        cause;
  logic              ready;
  logic              accept;
  logic              vld_p1;
  logic              vld_p2;

  logic [INST_W-1:0] req_inst_p1;
  logic [XLEN-1:0]   req_addr_p1;
  logic [XLEN-1:0]   req_wdata_p1;
  logic              req_load_p1;

  logic              rec_we_p2;
  logic [4:0]        rec_rd_p2;
  logic [XLEN-1:0]   rec_data_p2;
  logic [XLEN-1:0]   rec_addr_p2;
  logic              rec_exc_p2;
  exc_cause_t        rec_cause_p2;

  assign ea = bus.ex_rs1 + bus.ex_imm;

  mem_align_check #(
    .XLEN     (XLEN),
    .INST_W   (INST_W),
    .MEM_SIZE (MEM_SIZE)
  ) u_align_check (
    .ea       (ea),
    .op       (bus.ex_inst),
    .is_load  (is_load),
    .is_store (is_store),
    .fault    (fault),
    .cause    (cause)
  );

  assign is_mem = is_load | is_store;
  assign ready  = (state == ST_IDLE) | ((state == ST_HOLD) & bus.wb_ready);
  assign accept = bus.ex_valid & ready;
  assign target = (is_mem & ~fault) ? ST_ACCESS : ST_HOLD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (accept) next_state = target;
      ST_ACCESS:  next_state = req_load_p1 ? ST_CAPTURE : ST_HOLD;
      ST_CAPTURE: next_state = ST_HOLD;
      ST_HOLD:    if (bus.wb_ready) next_state = accept ? target : ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // p1: dataMem request, captured on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      req_inst_p1  <= bus.ex_inst & INST_W'(LOAD_MASK | STORE_MASK);
      req_addr_p1  <= ea;
      req_wdata_p1 <= bus.ex_rs2;
      req_load_p1  <= is_load;
    end
  end

  // p2: write-back record; load data is written in when CAPTURE closes
  always_ff @(posedge clk) begin
    if (accept) begin
      rec_we_p2    <= ~fault & ~is_store & (bus.ex_rd != 5'd0);
      rec_rd_p2    <= bus.ex_rd;
      rec_data_p2  <= is_mem ? '0 : bus.ex_alu_result;
      rec_addr_p2  <= ea;
      rec_exc_p2   <= fault;
      rec_cause_p2 <= cause;
    end else if (state == ST_CAPTURE) begin
      rec_data_p2  <= bus.dmem_rdata;
    end
  end

  // Outputs are gated by state so reset alone clears them without touching data regs
  assign vld_p1 = (state == ST_ACCESS);
  assign vld_p2 = (state == ST_HOLD);

  assign bus.ex_ready   = ready;
  assign bus.dmem_inst  = vld_p1 ? req_inst_p1  : '0;
  assign bus.dmem_addr  = vld_p1 ? req_addr_p1  : '0;
  assign bus.dmem_wdata = vld_p1 ? req_wdata_p1 : '0;

  assign bus.wb_valid  = vld_p2;
  assign bus.wb_we     = vld_p2 & rec_we_p2;
  assign bus.wb_rd     = vld_p2 ? rec_rd_p2 : '0;
  assign bus.wb_data   = vld_p2 ? rec_data_p2 : '0;
  assign bus.exc_valid = vld_p2 & rec_exc_p2;
  assign bus.exc_cause = vld_p2 ? rec_cause_p2 : EXC_NONE;
  assign bus.exc_addr  = (vld_p2 & rec_exc_p2) ? rec_addr_p2 : '0;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: dataMem stand-in, queue-based transaction model checked
// every cycle, directed literal cases and a randomized run with WB back-pressure.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if #(.XLEN(32), .INST_W(64)) bus ();

  mem_access_stage #(.XLEN(32), .INST_W(64), .MEM_SIZE(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- dataMem stand-in ----------------
  logic [7:0]  dm_mem  [4096];
  logic [7:0]  ref_mem [4096];
  logic [31:0] dm_rdata;
  assign bus.dmem_rdata = dm_rdata;

  always @(posedge clk) begin : datamem
    int a;
    a = int'(bus.dmem_addr[11:0]);
    case (bus.dmem_inst)
      INST_SB: dm_mem[a] = bus.dmem_wdata[7:0];
      INST_SH: begin dm_mem[a] = bus.dmem_wdata[7:0]; dm_mem[a+1] = bus.dmem_wdata[15:8]; end
      INST_SW: begin
        dm_mem[a]   = bus.dmem_wdata[7:0];   dm_mem[a+1] = bus.dmem_wdata[15:8];
        dm_mem[a+2] = bus.dmem_wdata[23:16]; dm_mem[a+3] = bus.dmem_wdata[31:24];
      end
      INST_LB:  dm_rdata = {{24{dm_mem[a][7]}}, dm_mem[a]};
      INST_LBU: dm_rdata = {24'd0, dm_mem[a]};
      INST_LH:  dm_rdata = {{16{dm_mem[a+1][7]}}, dm_mem[a+1], dm_mem[a]};
      INST_LHU: dm_rdata = {16'd0, dm_mem[a+1], dm_mem[a]};
      INST_LW:  dm_rdata = {dm_mem[a+3], dm_mem[a+2], dm_mem[a+1], dm_mem[a]};
      default: ;
    endcase
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] inst;
    logic [31:0] ea;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          we;
    bit          exc;
    bit          access;
    bit          st;
    logic [1:0]  cause;
    int          size;
    int          acyc;
    int          vcyc;
  } rec_t;

  rec_t q[$];
  int   cyc = 0;

  function automatic rec_t make_rec(logic [63:0] inst, logic [31:0] rs1, logic [31:0] imm,
                                    logic [31:0] rs2, logic [4:0] rd, logic [31:0] alu, int acc);
    rec_t r;
    bit ld, sgn, mis, oor;
    int lat;
    logic [31:0] v;
    ld    = (inst == INST_LB) || (inst == INST_LH) || (inst == INST_LW) ||
            (inst == INST_LBU) || (inst == INST_LHU);
    r.st  = (inst == INST_SB) || (inst == INST_SH) || (inst == INST_SW);
    sgn   = (inst == INST_LB) || (inst == INST_LH);
    if ((inst == INST_LB) || (inst == INST_LBU) || (inst == INST_SB)) r.size = 1;
    else if ((inst == INST_LH) || (inst == INST_LHU) || (inst == INST_SH)) r.size = 2;
    else r.size = 4;
    r.inst   = inst;
    r.ea     = rs1 + imm;
    r.wdata  = rs2;
    r.rd     = rd;
    mis      = (r.ea % r.size) != 0;
    oor      = r.ea >= 32'd4096;
    r.exc    = (ld || r.st) && (mis || oor);
    r.cause  = mis ? (ld ? 2'b01 : 2'b10) : 2'b11;
    r.access = (ld || r.st) && !r.exc;
    r.we     = !r.exc && !r.st && (rd != 5'd0);
    if (r.st) r.data = 32'd0;
    else if (ld && r.access) begin
      v = 32'd0;
      for (int i = 0; i < r.size; i++) v = v | (32'(ref_mem[int'(r.ea[11:0]) + i]) << (8 * i));
      if (sgn && r.size == 1) v = {{24{v[7]}}, v[7:0]};
      if (sgn && r.size == 2) v = {{16{v[15]}}, v[15:0]};
      r.data = v;
    end else r.data = alu;
    lat    = !r.access ? 1 : (ld ? 3 : 2);
    r.acyc = acc;
    r.vcyc = acc + lat - 1;
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit rdy;
    if (!reset) q.delete();
    else begin
      rdy = (q.size() == 0) || (q[0].vcyc <= cyc && bus.wb_ready);
      if (q.size() > 0 && q[0].access && q[0].st && q[0].acyc == cyc)
        for (int i = 0; i < q[0].size; i++)
          ref_mem[int'(q[0].ea[11:0]) + i] = q[0].wdata[8*i +: 8];
      if (q.size() > 0 && q[0].vcyc <= cyc && bus.wb_ready) void'(q.pop_front());
      if (bus.ex_valid && rdy)
        q.push_back(make_rec(bus.ex_inst, bus.ex_rs1, bus.ex_imm, bus.ex_rs2, bus.ex_rd,
                             bus.ex_alu_result, cyc + 1));
      cyc++;
    end
  end

  always @(negedge clk) begin : compare
    bit hold, erdy;
    logic [63:0] einst;
    hold  = (q.size() > 0) && (q[0].vcyc <= cyc);
    erdy  = (q.size() == 0) || (hold && bus.wb_ready);
    einst = 64'd0;
    if (q.size() > 0 && q[0].access && q[0].acyc == cyc) einst = q[0].inst;
    check("ex_ready", bus.ex_ready, erdy);
    check("wb_valid", bus.wb_valid, hold);
    check("dmem_inst", bus.dmem_inst, einst);
    if (einst != 64'd0) begin
      check("dmem_addr", bus.dmem_addr, q[0].ea);
      check("dmem_wdata", bus.dmem_wdata, q[0].wdata);
    end
    if (hold) begin
      check("wb_we", bus.wb_we, q[0].we);
      check("exc_valid", bus.exc_valid, q[0].exc);
      if (q[0].we) check("wb_rd", bus.wb_rd, q[0].rd);
      if (!q[0].exc) check("wb_data", bus.wb_data, q[0].data);
      if (q[0].exc) begin
        check("exc_cause", bus.exc_cause, q[0].cause);
        check("exc_addr", bus.exc_addr, q[0].ea);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(logic [63:0] inst, logic [31:0] rs1, logic [31:0] imm,
                       logic [31:0] rs2, logic [4:0] rd, logic [31:0] alu);
    bus.ex_inst = inst; bus.ex_rs1 = rs1; bus.ex_imm = imm;
    bus.ex_rs2 = rs2; bus.ex_rd = rd; bus.ex_alu_result = alu;
  endtask

  // Issues one op, returns edges to wb_valid and dataMem activity seen; ends at a negedge.
  task automatic run_op(string tag, logic [63:0] inst, logic [31:0] rs1, logic [31:0] imm,
                        logic [31:0] rs2, logic [4:0] rd, logic [31:0] alu,
                        output int lat, output int dcyc, output logic [31:0] daddr);
    bit acc;
    int n;
    @(posedge clk); #1;
    drive(inst, rs1, imm, rs2, rd, alu);
    bus.ex_valid = 1'b1;
    acc = 1'b0; lat = -1; dcyc = 0; daddr = 32'd0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = bus.ex_ready;
      @(posedge clk);
    end
    #1 bus.ex_valid = 1'b0;
    if (!acc) begin check({tag, "_accept_timeout"}, 64'd0, 64'd1); return; end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.dmem_inst != 64'd0) begin dcyc++; daddr = bus.dmem_addr; end
      if (bus.wb_valid) begin lat = n; break; end
      @(posedge clk); n++;
    end
    if (lat < 0) check({tag, "_wb_timeout"}, 64'd0, 64'd1);
  endtask

  localparam logic [63:0] INST_ADD = 64'd1 << 20;

  initial begin
    int lat, dc;
    logic [31:0] da;
    bit got;
    for (int i = 0; i < 4096; i++) begin
      dm_mem[i]  = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    dm_rdata = 32'd0;
    bus.ex_valid = 1'b0; bus.wb_ready = 1'b1;
    drive(64'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_ex_ready", bus.ex_ready, 1);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_dmem_inst", bus.dmem_inst, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_exc_valid", bus.exc_valid, 0);
    @(posedge clk); #1 reset = 1'b1;

    run_op("sw", INST_SW, 32'h4, 32'h4, 32'hDEADBEEF, 5'd1, 32'd0, lat, dc, da);
    check("sw_lat", 64'(lat), 2); check("sw_dmem_cycles", 64'(dc), 1);
    check("sw_dmem_addr", da, 32'h8); check("sw_we", bus.wb_we, 0);

    run_op("lw", INST_LW, 32'h8, 32'h0, 32'h0, 5'd5, 32'd0, lat, dc, da);
    check("lw_lat", 64'(lat), 3); check("lw_rd", bus.wb_rd, 5);
    check("lw_data", bus.wb_data, 32'hDEADBEEF); check("lw_we", bus.wb_we, 1);

    run_op("sb", INST_SB, 32'h4, 32'h0, 32'h123456AA, 5'd0, 32'd0, lat, dc, da);
    run_op("lb", INST_LB, 32'h4, 32'h0, 32'h0, 5'd7, 32'd0, lat, dc, da);
    check("lb_data", bus.wb_data, 32'hFFFFFFAA);
    run_op("lbu", INST_LBU, 32'h2, 32'h2, 32'h0, 5'd8, 32'd0, lat, dc, da);
    check("lbu_data", bus.wb_data, 32'h000000AA);

    run_op("lh_mis", INST_LH, 32'h7, 32'h0, 32'h0, 5'd9, 32'd0, lat, dc, da);
    check("lh_mis_lat", 64'(lat), 1); check("lh_mis_dmem", 64'(dc), 0);
    check("lh_mis_exc", bus.exc_valid, 1); check("lh_mis_cause", bus.exc_cause, 2'b01);
    check("lh_mis_addr", bus.exc_addr, 32'h7); check("lh_mis_we", bus.wb_we, 0);

    run_op("sw_oor", INST_SW, 32'h1000, 32'h0, 32'h1, 5'd0, 32'd0, lat, dc, da);
    check("sw_oor_cause", bus.exc_cause, 2'b11); check("sw_oor_dmem", 64'(dc), 0);

    run_op("wrap", INST_LW, 32'hFFFFFFFC, 32'h10, 32'h0, 5'd10, 32'd0, lat, dc, da);
    check("wrap_exc", bus.exc_valid, 0); check("wrap_data", bus.wb_data, 32'h55545756);

    run_op("nm_rd0", INST_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 32'h1234, lat, dc, da);
    check("nm_rd0_we", bus.wb_we, 0); check("nm_rd0_lat", 64'(lat), 1);
    run_op("nm", INST_ADD, 32'h0, 32'h0, 32'h0, 5'd3, 32'hCAFEF00D, lat, dc, da);
    check("nm_we", bus.wb_we, 1); check("nm_data", bus.wb_data, 32'hCAFEF00D);

    // back-pressure during a load, then back-to-back accept on release
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    drive(INST_LW, 32'h8, 32'h0, 32'h0, 5'd6, 32'd0);
    bus.ex_valid = 1'b1;
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = bus.wb_valid; end
    check("bp_wb_valid", bus.wb_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_data", bus.wb_data, 32'hDEADBEEF); check("bp_valid", bus.wb_valid, 1);
      check("bp_ex_ready", bus.ex_ready, 0); check("bp_dmem_inst", bus.dmem_inst, 0);
    end
    @(posedge clk); #1;
    bus.wb_ready = 1'b1;
    drive(INST_ADD, 32'h0, 32'h0, 32'h0, 5'd11, 32'h77);
    bus.ex_valid = 1'b1;
    @(negedge clk); check("b2b_ex_ready", bus.ex_ready, 1);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(negedge clk);
    check("b2b_wb_valid", bus.wb_valid, 1); check("b2b_rd", bus.wb_rd, 11);
    check("b2b_data", bus.wb_data, 32'h77);

    // reset while a store is in ACCESS: store must not retire
    @(posedge clk); #1;
    drive(INST_SW, 32'h100, 32'h0, 32'h11223344, 5'd0, 32'd0);
    bus.ex_valid = 1'b1;
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    check("rst_pre_access", bus.dmem_inst, INST_SW);
    reset = 1'b0;
    #1;
    check("rst_mid_dmem", bus.dmem_inst, 0); check("rst_mid_ready", bus.ex_ready, 1);
    check("rst_mid_wb_valid", bus.wb_valid, 0);
    @(posedge clk); #1 reset = 1'b1;
    run_op("rst_lw", INST_LW, 32'h100, 32'h0, 32'h0, 5'd12, 32'd0, lat, dc, da);
    check("rst_lw_data", bus.wb_data, 32'h59585B5A);

    // randomized traffic with random back-pressure
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [63:0] inst;
      logic [31:0] rs1;
      @(posedge clk); #1;
      k = $urandom_range(0, 8);
      case (k)
        0: inst = INST_LB;  1: inst = INST_LH;  2: inst = INST_LW;
        3: inst = INST_LBU; 4: inst = INST_LHU; 5: inst = INST_SB;
        6: inst = INST_SH;  7: inst = INST_SW;
        default: inst = 64'd1 << (($urandom % 2) != 0 ? $urandom_range(0, 9) : $urandom_range(18, 63));
      endcase
      rs1 = (($urandom % 8) == 0) ? $urandom : 32'($urandom_range(0, 4100));
      drive(inst, rs1, 32'($urandom_range(0, 64)) - 32'd32, $urandom, 5'($urandom_range(0, 31)),
            $urandom);
      bus.ex_valid = ($urandom % 4) != 0;
      bus.wb_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    bus.ex_valid = 1'b0; bus.wb_ready = 1'b1;
    repeat (8) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
